// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT writeback path: state encoding, default widths
// and an address bit-reversal helper.
package ntt_pkg;

  localparam int NTT_ADDR_W = 8;
  localparam int NTT_DATA_W = 32;
  localparam int NTT_PAIR_W = 2 * NTT_ADDR_W;
  localparam int BITREV_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2,
    FIN  = 2'd3
  } wb_state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX-1:0] bit_rev(input logic [BITREV_MAX-1:0] v, input int w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_fifo.sv
// In-order address-pair FIFO, zero-latency head (an empty FIFO forwards the push data).
// Push while full is dropped unless a pop frees the slot in the same cycle; ovf_o flags the drop.
module ntt_addr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               push_dat_i,
  output logic [W-1:0]               head_dat_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   cnt_q;
  logic          full, do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == (PW+1)'(DEPTH));
  assign do_push    = push_i && (!full || pop_i);
  assign do_pop     = pop_i && (!empty_o || push_i);
  assign ovf_o      = push_i && full && !pop_i;
  assign head_dat_o = empty_o ? push_dat_i : mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

  // Push+pop on an empty FIFO writes a slot that both pointers then step past.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ntt_writeback_sequencer.sv
// Queues NTT operand address pairs at read issue and writes each result pair back A then B
// (accept->A 1 cycle, ->B 2 cycles); stall while the FIFO is full. NTT_WB_BITREV_EN adds bitrev.
module ntt_writeback_sequencer
  import ntt_pkg::*;
#(
  parameter int ADDR_W     = NTT_ADDR_W,
  parameter int DATA_W     = NTT_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
`ifdef NTT_WB_BITREV_EN
  input  logic              bitrev,
`endif
  input  logic              start,
  input  logic [CNT_W-1:0]  n_pairs,
  input  logic              rd_issue,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              bf_valid,
  input  logic [DATA_W-1:0] bf_a,
  input  logic [DATA_W-1:0] bf_b,
  output logic              bf_ready,
  output logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PAIR_W = 2 * ADDR_W;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_state_e         state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, b_data_q, b_data_d;
  logic [CNT_W-1:0]  n_pairs_q, n_pairs_d, cnt_q, cnt_d;

  logic              push, pop, flush, fifo_empty, fifo_ovf;
  logic [PAIR_W-1:0] head;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [ADDR_W-1:0] head_a, head_b, a_wr, b_wr;

  assign push     = rd_issue && busy_q;
  assign bf_ready = (state_q == WR_A) && (!fifo_empty || push);
  assign pop      = bf_valid && bf_ready;
  assign stall    = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
  assign head_a   = head[PAIR_W-1:ADDR_W];
  assign head_b   = head[ADDR_W-1:0];

  ntt_addr_fifo #(.W(PAIR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .push_dat_i({rd_addr_a, rd_addr_b}),
    .head_dat_o(head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt),
    .ovf_o     (fifo_ovf)
  );

`ifdef NTT_WB_BITREV_EN
  logic bitrev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bitrev_q <= 1'b0;
    else if (state_q == IDLE && start) bitrev_q <= bitrev;
  end
  // Reversal applies only on the write side; queued addresses stay as issued.
  assign a_wr = bitrev_q ? ADDR_W'(bit_rev(BITREV_MAX'(head_a), ADDR_W)) : head_a;
  assign b_wr = bitrev_q ? ADDR_W'(bit_rev(BITREV_MAX'(b_addr_q), ADDR_W)) : b_addr_q;
`else
  assign a_wr = head_a;
  assign b_wr = b_addr_q;
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    n_pairs_d = n_pairs_q;
    cnt_d     = cnt_q;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_pairs_d = n_pairs;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = (n_pairs == '0) ? FIN : WR_A;
        end
      end
      WR_A: begin
        if (pop) begin
          b_addr_d  = head_b;
          b_data_d  = bf_b;
          wr_en_d   = 1'b1;
          wr_addr_d = a_wr;
          wr_data_d = bf_a;
          state_d   = WR_B;
        end else if (bf_valid && fifo_empty && !push) begin
          err_d = 1'b1;
        end
      end
      WR_B: begin
        wr_en_d   = 1'b1;
        wr_addr_d = b_wr;
        wr_data_d = b_data_q;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = (cnt_q + CNT_W'(1) == n_pairs_q) ? FIN : WR_A;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fifo_ovf) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      n_pairs_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      n_pairs_q <= n_pairs_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
